// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_encoder
//  Purpose  : Debounced ten-key numeric keypad front end. Turns one-hot key
//             lines into a BCD digit plus a one-cycle digit-valid strobe,
//             rejecting bounce, multi-key presses and locked-out presses.
//  Options  : KEYPAD_REPEAT_EN - when defined, a key held in HOLD re-issues
//             its digit every REPEAT_CYCLES cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 50
) (
    input  logic       clock,
    input  logic       Cn,
    input  logic [9:0] keypad,
    input  logic       enablen,
    output logic [3:0] D,
    output logic       dv,
    output logic       busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;
    localparam logic [1:0] S_HOLD     = 2'd3;

    // Press and release counts both end on the cycle their count reaches
    // DEBOUNCE_CYCLES, so the decision compares against the value before it.
    localparam logic [7:0] C_DEB      = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] C_DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [9:0] r_sync1;
    logic [9:0] r_ks;
    logic [1:0] r_state;
    logic [1:0] w_state_nx;
    logic [3:0] r_code;
    logic [3:0] w_code_nx;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nx;
    logic [7:0] r_rel;
    logic [7:0] w_rel_nx;
    logic [3:0] r_d;
    logic [3:0] w_d_nx;
    logic       r_dv;
    logic       w_dv_nx;
    logic       r_busy;
    logic [3:0] w_key_code;
    logic       w_key_valid;
    logic       w_same_key;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] C_RPT_LAST = 8'(REPEAT_CYCLES - 1);
    logic [7:0] r_rpt;
    logic [7:0] w_rpt_nx;
    logic [9:0] w_held_hot;
    assign w_held_hot = 10'd1 << r_code;
`else
    // Repeat period has no meaning without the repeat feature.
    logic [7:0] w_unused_rpt;
    assign w_unused_rpt = 8'(REPEAT_CYCLES);
`endif

    // Two-flop synchronizer for the asynchronous key lines
    always_ff @(posedge clock) begin
        if (!Cn) begin
            r_sync1 <= '0;
            r_ks    <= '0;
        end else begin
            r_sync1 <= keypad;
            r_ks    <= r_sync1;
        end
    end

    // Index of the highest set key line; only trusted when exactly one is set
    always_comb begin
        w_key_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_ks[i]) w_key_code = 4'(i);
        end
    end

    assign w_key_valid = (r_ks != 10'd0) && ((r_ks & (r_ks - 10'd1)) == 10'd0);
    assign w_same_key  = w_key_valid && (w_key_code == r_code);

    // Next-state and next-output decisions for the press/issue/release cycle
    always_comb begin
        w_state_nx = r_state;
        w_code_nx  = r_code;
        w_cnt_nx   = r_cnt;
        w_rel_nx   = r_rel;
        w_d_nx     = r_d;
        w_dv_nx    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_rpt_nx   = r_rpt;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = 8'd0;
                w_rel_nx = 8'd0;
                if (!enablen && w_key_valid) begin
                    w_state_nx = S_DEBOUNCE;
                    w_code_nx  = w_key_code;
                    w_cnt_nx   = 8'd1;
                end
            end
            S_DEBOUNCE: begin
                if (!enablen && w_same_key) begin
                    w_cnt_nx = r_cnt + 8'd1;
                    if (r_cnt == C_DEB_LAST) w_state_nx = S_ISSUE;
                end else begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = 8'd0;
                end
            end
            S_ISSUE: begin
                w_d_nx     = r_code;
                w_dv_nx    = 1'b1;
                w_state_nx = S_HOLD;
                w_cnt_nx   = 8'd0;
                w_rel_nx   = 8'd0;
`ifdef KEYPAD_REPEAT_EN
                w_rpt_nx   = 8'd0;
`endif
            end
            S_HOLD: begin
                // Any activity on the lines restarts the release count.
                if (r_ks == 10'd0) begin
                    if (r_rel < C_DEB) w_rel_nx = r_rel + 8'd1;
                    if (r_rel == C_DEB_LAST) w_state_nx = S_IDLE;
                end else begin
                    w_rel_nx = 8'd0;
                end
`ifdef KEYPAD_REPEAT_EN
                // Repeat counting keeps running while locked out; only the
                // strobe itself is suppressed.
                if (r_ks == w_held_hot) begin
                    if (r_rpt == C_RPT_LAST) begin
                        w_rpt_nx = 8'd0;
                        w_dv_nx  = !enablen;
                    end else begin
                        w_rpt_nx = r_rpt + 8'd1;
                    end
                end else begin
                    w_rpt_nx = 8'd0;
                end
`endif
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (!Cn) begin
            r_state <= S_IDLE;
            r_code  <= 4'd0;
            r_cnt   <= 8'd0;
            r_rel   <= 8'd0;
            r_d     <= 4'd0;
            r_dv    <= 1'b0;
            r_busy  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rpt   <= 8'd0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_code  <= w_code_nx;
            r_cnt   <= w_cnt_nx;
            r_rel   <= w_rel_nx;
            r_d     <= w_d_nx;
            r_dv    <= w_dv_nx;
            r_busy  <= (w_state_nx != S_IDLE);
`ifdef KEYPAD_REPEAT_EN
            r_rpt   <= w_rpt_nx;
`endif
        end
    end

    assign D    = r_d;
    assign dv   = r_dv;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_encoder
//  Purpose  : Self-checking bench for keypad_encoder: directed scenarios with
//             literal expectations plus randomized key activity compared
//             every cycle against a behavioural model.
//  Options  : KEYPAD_REPEAT_EN changes the expected repeat behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_encoder;

    localparam int DEB = 4;
    localparam int RPT = 10;

    logic       clock   = 1'b0;
    logic       Cn      = 1'b0;
    logic [9:0] keypad  = 10'd0;
    logic       enablen = 1'b1;
    logic [3:0] D;
    logic       dv;
    logic       busy;

    keypad_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clock  (clock),
        .Cn     (Cn),
        .keypad (keypad),
        .enablen(enablen),
        .D      (D),
        .dv     (dv),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: a press is a run of DEB consecutive synchronized
    // samples of one lone key with entry enabled; the digit comes out one
    // cycle later and the keypad stays locked until DEB zero samples.
    logic [9:0] m_s1 = '0;
    logic [9:0] m_ks = '0;
    int         arm_key  = -1;
    int         run      = 0;
    int         zeros    = 0;
    int         rep      = 0;
    int         pend_key = 0;
    int         m_k      = -1;
    bit         pend     = 0;
    bit         locked   = 0;
    int         exp_d    = 0;
    int         exp_dv   = 0;
    int         exp_busy = 0;

    int pulse_cyc[$];
    int pulse_d[$];
    int fall_cyc[$];
    int prev_busy = 0;

    function automatic int lone_key(input logic [9:0] v);
        int n;
        int idx;
        n   = 0;
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d cycle=%0d", name, actual, expected, cyc);
        end
    endtask

    task automatic model_edge();
        if (!Cn) begin
            m_s1 = '0; m_ks = '0;
            arm_key = -1; run = 0; zeros = 0; rep = 0;
            pend = 0; locked = 0;
            exp_d = 0; exp_dv = 0; exp_busy = 0;
        end else begin
            m_k    = lone_key(m_ks);
            exp_dv = 0;
            if (pend) begin
                exp_dv = 1;
                exp_d  = pend_key;
                pend   = 0;
                locked = 1;
                zeros  = 0;
                rep    = 0;
            end else if (locked) begin
                if (m_ks == 10'd0) begin
                    zeros++;
                    if (zeros == DEB) locked = 0;
                end else begin
                    zeros = 0;
                end
`ifdef KEYPAD_REPEAT_EN
                if (m_k == exp_d) begin
                    rep++;
                    if (rep == RPT) begin
                        rep    = 0;
                        exp_dv = enablen ? 0 : 1;
                    end
                end else begin
                    rep = 0;
                end
`endif
            end else if (arm_key >= 0) begin
                if (m_k == arm_key && !enablen) begin
                    run++;
                    if (run == DEB) begin
                        pend     = 1;
                        pend_key = arm_key;
                        arm_key  = -1;
                    end
                end else begin
                    arm_key = -1;
                end
            end else if (m_k >= 0 && !enablen) begin
                arm_key = m_k;
                run     = 1;
            end
            exp_busy = (pend || locked || arm_key >= 0) ? 1 : 0;
            m_ks = m_s1;
            m_s1 = keypad;
        end
    endtask

    // One clock: apply inputs, advance model at the edge, compare mid-cycle.
    task automatic step(input logic [9:0] kp, input logic en, input logic cn);
        keypad  = kp;
        enablen = en;
        Cn      = cn;
        @(posedge clock);
        cyc++;
        model_edge();
        @(negedge clock);
        check("dv", int'(dv), exp_dv);
        check("D", int'(D), exp_d);
        check("busy", int'(busy), exp_busy);
        if (dv) begin
            pulse_cyc.push_back(cyc);
            pulse_d.push_back(int'(D));
        end
        if (prev_busy == 1 && !busy) fall_cyc.push_back(cyc);
        prev_busy = int'(busy);
    endtask

    task automatic hold(input logic [9:0] kp, input logic en, input int n);
        for (int i = 0; i < n; i++) step(kp, en, 1'b1);
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_d.delete();
        fall_cyc.delete();
    endtask

    function automatic int pulse_at(input int i);
        return (i < pulse_cyc.size()) ? pulse_cyc[i] : -1;
    endfunction

    function automatic int code_at(input int i);
        return (i < pulse_d.size()) ? pulse_d[i] : -1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int tr;
        int len;
        int sel;
        logic [9:0] kp;
        logic en;

        // Reset with key 7 held; digit 7 arrives 6 edges after release.
        step(10'h080, 1'b0, 1'b0);
        step(10'h080, 1'b0, 1'b0);
        check("reset_D", int'(D), 0);
        check("reset_dv", int'(dv), 0);
        check("reset_busy", int'(busy), 0);
        clear_log();
        t0 = cyc + 1;
        hold(10'h080, 1'b0, 10);
        check("reset_key_count", pulse_cyc.size(), 1);
        check("reset_key_cycle", pulse_at(0), t0 + 6);
        check("reset_key_D", code_at(0), 7);
        hold(10'h000, 1'b0, 10);

        // Clean press of key 1
        clear_log();
        t0 = cyc + 1;
        hold(10'h002, 1'b0, 10);
        tr = cyc + 1;
        hold(10'h000, 1'b0, 10);
        check("clean_count", pulse_cyc.size(), 1);
        check("clean_cycle", pulse_at(0), t0 + 6);
        check("clean_D", code_at(0), 1);
        check("clean_busy_fall", (fall_cyc.size() > 0) ? fall_cyc[0] : -1, tr + 5);

        // Bouncing key 9, then settled
        clear_log();
        for (int i = 0; i < 3; i++) begin
            hold(10'h200, 1'b0, 2);
            hold(10'h000, 1'b0, 2);
        end
        check("bounce_quiet", pulse_cyc.size(), 0);
        t0 = cyc + 1;
        hold(10'h200, 1'b0, 12);
        hold(10'h000, 1'b0, 10);
        check("bounce_count", pulse_cyc.size(), 1);
        check("bounce_cycle", pulse_at(0), t0 + 6);
        check("bounce_D", code_at(0), 9);

        // Two keys at once
        clear_log();
        hold(10'h011, 1'b0, 20);
        hold(10'h000, 1'b0, 6);
        check("multikey_count", pulse_cyc.size(), 0);

        // Key 3 while locked out, then entry enabled with key still held
        clear_log();
        hold(10'h008, 1'b1, 10);
        check("lockout_count", pulse_cyc.size(), 0);
        t0 = cyc + 1;
        hold(10'h008, 1'b0, 10);
        hold(10'h000, 1'b0, 10);
        check("unlock_count", pulse_cyc.size(), 1);
        check("unlock_cycle", pulse_at(0), t0 + 4);
        check("unlock_D", code_at(0), 3);

        // Entry sequence 1, 9, 9
        clear_log();
        hold(10'h002, 1'b0, 8); hold(10'h000, 1'b0, 8);
        hold(10'h200, 1'b0, 8); hold(10'h000, 1'b0, 8);
        hold(10'h200, 1'b0, 8); hold(10'h000, 1'b0, 8);
        check("seq_count", pulse_cyc.size(), 3);
        check("seq_D0", code_at(0), 1);
        check("seq_D1", code_at(1), 9);
        check("seq_D2", code_at(2), 9);

        // Key 5 held for 40 cycles
        clear_log();
        t0 = cyc + 1;
        hold(10'h020, 1'b0, 40);
        hold(10'h000, 1'b0, 10);
`ifdef KEYPAD_REPEAT_EN
        check("repeat_count", pulse_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("repeat_cycle", pulse_at(i), t0 + 6 + 10 * i);
            check("repeat_D", code_at(i), 5);
        end
`else
        check("repeat_count", pulse_cyc.size(), 1);
        check("repeat_cycle", pulse_at(0), t0 + 6);
        check("repeat_D", code_at(0), 5);
`endif

        // Randomized key activity against the model
        for (int seg = 0; seg < 120; seg++) begin
            sel = $urandom_range(0, 11);
            en  = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
            if (seg == 60) begin
                step(10'h010, 1'b0, 1'b0);
                step(10'h010, 1'b0, 1'b0);
            end
            if (sel <= 4) begin
                kp  = 10'd1 << $urandom_range(0, 9);
                len = $urandom_range(1, 12);
                hold(kp, en, len);
            end else if (sel <= 6) begin
                hold(10'h000, en, $urandom_range(1, 10));
            end else if (sel == 7) begin
                kp = (10'd1 << $urandom_range(0, 4)) | (10'd1 << $urandom_range(5, 9));
                hold(kp, en, $urandom_range(1, 8));
            end else if (sel == 8) begin
                len = $urandom_range(1, 5);
                for (int i = 0; i < len; i++) step(10'($urandom), en, 1'b1);
            end else if (sel == 9) begin
                kp  = 10'd1 << $urandom_range(0, 9);
                len = $urandom_range(6, 14);
                for (int i = 0; i < len; i++) step(kp, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'b1);
            end else begin
                kp = 10'd1 << $urandom_range(0, 9);
                hold(kp, en, $urandom_range(20, 35));
            end
        end
        hold(10'h000, 1'b0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
